serial_addsub_ctrl: RTL

- Bit-serial add/subtract engine built around the team's 1-bit add/sub cell (one full adder, with `b` conditionally inverted by `selec`).
- Upstream role: shifts operand bits LSB-first into the cell and supplies the carry-in each cycle.
- Downstream role: captures the cell's sum bit into a result shift register and its carry-out into a carry flip-flop.
- Gives the ALU datapath a multi-bit add/sub from a single cell, with a start/done handshake.

---
 rtl/serial_addsub_ctrl_if.sv | 32 +++
 rtl/serial_addsub_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_addsub_ctrl_if
//  Purpose  : Request/result bundle for the bit-serial add/sub engine.
//             The master drives the operands and the start pulse; the slave
//             (the engine) returns status, result and flags.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             selec;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;

  modport master (
    output start, selec, a, b,
    input  busy, done, out, cout, ovf
  );

  modport slave (
    input  start, selec, a, b,
    output busy, done, out, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_addsub_ctrl
//  Purpose  : Multi-bit add/subtract built from a single 1-bit add/sub cell.
//             Operands are shifted through the cell LSB-first, one bit per
//             clock; the sum bits are collected MSB-in into a result register.
//             Subtract is a + ~b + 1, the +1 coming from the preset carry.
//  Revision : 1.0  initial release
// ============================================================================
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_addsub_ctrl_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] out_q;
  logic [CW-1:0]    cnt_q;
  logic             sel_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  // The 1-bit add/sub cell working on the current LSBs.
  logic             b_eff;
  logic             sum_bit;
  logic             carry_d;
  logic [WIDTH-1:0] res_d;

  assign b_eff   = sb_q[0] ^ sel_q;
  assign sum_bit = sa_q[0] ^ b_eff ^ carry_q;
  assign carry_d = (sa_q[0] & b_eff) | (sa_q[0] & carry_q) | (b_eff & carry_q);
  assign res_d   = {sum_bit, res_q[WIDTH-1:1]};

  // Control FSM and serial datapath; every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        // DONE behaves like IDLE for accepting a new request, so a start
        // presented during the done pulse chains operations back-to-back.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            sel_q   <= bus.selec;
            carry_q <= bus.selec;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end

        RUN: begin
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          res_q   <= res_d;
          carry_q <= carry_d;
          if (cnt_q == LAST_BIT) begin
            // Carry into the MSB is carry_q; carry out of it is carry_d.
            out_q   <= res_d;
            cout_q  <= carry_d;
            ovf_q   <= carry_q ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
`default_nettype wire
